// File: rtl/score_recorder_pkg.sv
// Shared constants, state encoding and key-decode helpers for the score recorder.
package score_recorder_pkg;

  localparam int unsigned NOTE_KEY_BITS = 7;
  localparam int unsigned NOTE_W        = 3;
  localparam int unsigned OCT_W         = 2;

  localparam logic [NOTE_W-1:0] REST_NOTE = '0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHold = 2'd1,
    StRest = 2'd2
  } rec_state_e;

  function automatic logic key_is_valid(input logic [NOTE_KEY_BITS-1:0] key);
    return $onehot(key);
  endfunction

  // Bit i of a one-hot key maps to note i+1; only meaningful for a valid key.
  function automatic logic [NOTE_W-1:0] key_to_note(input logic [NOTE_KEY_BITS-1:0] key);
    logic [NOTE_W-1:0] n;
    n = '0;
    for (int i = 0; i < NOTE_KEY_BITS; i++) begin
      if (key[i]) n = NOTE_W'(i + 1);
    end
    return n;
  endfunction

endpackage

// File: rtl/score_recorder_tick.sv
// Duration prescaler: tick_o pulses every TICK_DIV cycles, counting restarts on restart_i.
module rec_tick #(
  parameter int unsigned TICK_DIV = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart_i,
  output logic tick_o
);

  localparam int unsigned    CntW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q + CntOne;
    if (restart_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/score_recorder.sv
// Score recorder: encodes live key/octave input into note/rest entries with tick durations.
// Define SCORE_REC_OCT_EN to store octave per entry and split a held note on octave change.
module score_recorder
  import score_recorder_pkg::*;
#(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned TICK_DIV = 1000000,
  parameter int unsigned DUR_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rec_en_i,
  input  logic                     clear_i,
  input  logic [NOTE_KEY_BITS-1:0] note_key_i,
  input  logic [OCT_W-1:0]         octave_i,
  input  logic                     rd_req_i,
  input  logic                     rd_rewind_i,
  output logic                     rd_valid_o,
  output logic [NOTE_W-1:0]        rd_note_o,
  output logic [OCT_W-1:0]         rd_oct_o,
  output logic [DUR_W-1:0]         rd_dur_o,
  output logic                     rd_last_o,
  output logic                     rd_empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     overflow_o,
  output logic                     recording_o
);

  localparam int unsigned      AddrW   = $clog2(DEPTH);
  localparam logic [AddrW:0]   CntOne  = (AddrW + 1)'(1);
  localparam logic [AddrW:0]   CntFull = (AddrW + 1)'(DEPTH);
  localparam logic [DUR_W-1:0] DurOne  = DUR_W'(1);
  localparam logic [DUR_W-1:0] DurMax  = '1;

  rec_state_e        state_q, state_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [DUR_W-1:0]  dur_q, dur_now;
  logic [AddrW:0]    count_q, rd_ptr_q;
  logic              overflow_q, rd_valid_q, rd_last_q, recording_q;
  logic [NOTE_W-1:0] rd_note_q;
  logic [DUR_W-1:0]  rd_dur_q;

  logic [NOTE_W-1:0] note_mem_q [DEPTH];
  logic [DUR_W-1:0]  dur_mem_q  [DEPTH];

  logic              tick, restart, seg_start;
  logic              key_valid, key_rel, oct_changed;
  logic [NOTE_W-1:0] key_note, commit_note;
  logic [DUR_W-1:0]  commit_dur;
  logic              commit, full, empty, wr_en, rd_fire;
  logic [AddrW-1:0]  wr_addr, rd_addr;

`ifdef SCORE_REC_OCT_EN
  logic [OCT_W-1:0] oct_q, oct_d, commit_oct, rd_oct_q;
  logic [OCT_W-1:0] oct_mem_q [DEPTH];

  assign oct_changed = (octave_i != oct_q);
  assign rd_oct_o    = rd_oct_q;
`else
  logic unused_octave;

  assign unused_octave = ^octave_i;
  assign oct_changed   = 1'b0;
  assign rd_oct_o      = '0;
`endif

  assign key_valid = key_is_valid(note_key_i);
  assign key_rel   = (note_key_i == '0);
  assign key_note  = key_to_note(note_key_i);

  // Duration including a tick landing on this edge, so a commit sees the full count.
  assign dur_now = (tick && (dur_q != DurMax)) ? dur_q + DurOne : dur_q;

  always_comb begin
    state_d     = state_q;
    note_d      = note_q;
    commit      = 1'b0;
    commit_note = note_q;
    commit_dur  = dur_now;
    seg_start   = 1'b0;
`ifdef SCORE_REC_OCT_EN
    oct_d       = oct_q;
    commit_oct  = oct_q;
`endif
    case (state_q)
      StIdle: begin
        if (rec_en_i && key_valid) begin
          state_d   = StHold;
          note_d    = key_note;
          seg_start = 1'b1;
        end
      end
      StHold: begin
        if (!rec_en_i) begin
          commit  = 1'b1;
          state_d = StIdle;
        end else if (key_rel) begin
          commit    = 1'b1;
          state_d   = StRest;
          seg_start = 1'b1;
        end else if ((key_valid && (key_note != note_q)) || oct_changed) begin
          // A multi-bit key alongside an octave change keeps the current note.
          commit    = 1'b1;
          seg_start = 1'b1;
          if (key_valid) note_d = key_note;
        end
        if (dur_now == '0) commit_dur = DurOne;
      end
      StRest: begin
        commit_note = REST_NOTE;
`ifdef SCORE_REC_OCT_EN
        commit_oct  = '0;
`endif
        if (!rec_en_i) begin
          state_d = StIdle;
        end else if (key_valid) begin
          commit    = (dur_now != '0);
          state_d   = StHold;
          note_d    = key_note;
          seg_start = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
`ifdef SCORE_REC_OCT_EN
    if (seg_start) oct_d = octave_i;
`endif
    if (clear_i) begin
      state_d   = StIdle;
      commit    = 1'b0;
      seg_start = 1'b0;
    end
  end

  assign restart = seg_start || (state_q == StIdle);
  assign full    = (count_q == CntFull);
  assign empty   = (rd_ptr_q == count_q);
  assign wr_en   = commit && !full;
  assign rd_fire = rd_req_i && !rd_rewind_i && !empty && !clear_i;
  assign wr_addr = count_q[AddrW-1:0];
  assign rd_addr = rd_ptr_q[AddrW-1:0];

  rec_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart_i(restart),
    .tick_o   (tick)
  );

  always_ff @(posedge clk) begin
    if (wr_en) begin
      note_mem_q[wr_addr] <= commit_note;
      dur_mem_q[wr_addr]  <= commit_dur;
`ifdef SCORE_REC_OCT_EN
      oct_mem_q[wr_addr]  <= commit_oct;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      note_q      <= '0;
      dur_q       <= '0;
      recording_q <= 1'b0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      rd_ptr_q    <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_note_q   <= '0;
      rd_dur_q    <= '0;
`ifdef SCORE_REC_OCT_EN
      oct_q       <= '0;
      rd_oct_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      note_q      <= note_d;
      dur_q       <= restart ? '0 : dur_now;
      recording_q <= (state_d != StIdle);
`ifdef SCORE_REC_OCT_EN
      oct_q       <= oct_d;
`endif
      if (clear_i)    count_q <= '0;
      else if (wr_en) count_q <= count_q + CntOne;

      if (clear_i)              overflow_q <= 1'b0;
      else if (commit && full)  overflow_q <= 1'b1;

      if (clear_i || rd_rewind_i) rd_ptr_q <= '0;
      else if (rd_fire)           rd_ptr_q <= rd_ptr_q + CntOne;

      rd_valid_q <= rd_fire;
      rd_last_q  <= rd_fire && ((rd_ptr_q + CntOne) == count_q);
      if (rd_fire) begin
        rd_note_q <= note_mem_q[rd_addr];
        rd_dur_q  <= dur_mem_q[rd_addr];
`ifdef SCORE_REC_OCT_EN
        rd_oct_q  <= oct_mem_q[rd_addr];
`endif
      end
    end
  end

  assign rd_valid_o  = rd_valid_q;
  assign rd_note_o   = rd_note_q;
  assign rd_dur_o    = rd_dur_q;
  assign rd_last_o   = rd_last_q;
  assign rd_empty_o  = empty;
  assign count_o     = count_q;
  assign full_o      = full;
  assign overflow_o  = overflow_q;
  assign recording_o = recording_q;

endmodule

// File: tb/tb_score_recorder.sv
// Bench for score_recorder: directed scenarios plus random play against a timestamp-based model.
module tb_score_recorder;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned DUR_W    = 4;
  localparam int          DUR_MAX  = (1 << DUR_W) - 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rec_en = 1'b0, clear = 1'b0, rd_req = 1'b0, rd_rewind = 1'b0;
  logic [6:0] note_key = '0;
  logic [1:0] octave = '0;

  logic             rd_valid, rd_last, rd_empty, full, overflow, recording;
  logic [2:0]       rd_note;
  logic [1:0]       rd_oct;
  logic [DUR_W-1:0] rd_dur;
  logic [2:0]       count;

  always #5 clk = ~clk;

  score_recorder #(
    .DEPTH   (DEPTH),
    .TICK_DIV(TICK_DIV),
    .DUR_W   (DUR_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rec_en_i   (rec_en),
    .clear_i    (clear),
    .note_key_i (note_key),
    .octave_i   (octave),
    .rd_req_i   (rd_req),
    .rd_rewind_i(rd_rewind),
    .rd_valid_o (rd_valid),
    .rd_note_o  (rd_note),
    .rd_oct_o   (rd_oct),
    .rd_dur_o   (rd_dur),
    .rd_last_o  (rd_last),
    .rd_empty_o (rd_empty),
    .count_o    (count),
    .full_o     (full),
    .overflow_o (overflow),
    .recording_o(recording)
  );

  // Model: entries are a queue; a segment's duration is the number of whole tick
  // periods between its start edge and the edge that ends it.
  typedef struct {
    int note;
    int oct;
    int dur;
  } ent_t;

  ent_t m_buf[$];
  int   m_mode;  // 0 idle, 1 note held, 2 rest
  int   m_note, m_oct, m_start, m_edge, m_rptr;
  bit   m_ovf;
  int   e_valid, e_note, e_oct, e_dur, e_last;
  int   n_tests = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int popcount7(input logic [6:0] k);
    int c = 0;
    for (int i = 0; i < 7; i++) c += int'(k[i]);
    return c;
  endfunction

  function automatic int key_idx(input logic [6:0] k);
    for (int i = 0; i < 7; i++) if (k[i]) return i + 1;
    return 0;
  endfunction

  task automatic m_commit(input int note, input int oct, input int dur);
    ent_t e;
    e.note = note;
    e.oct  = oct;
    e.dur  = dur;
    if (m_buf.size() < DEPTH) m_buf.push_back(e);
    else m_ovf = 1'b1;
  endtask

  task automatic model_reset();
    m_buf.delete();
    m_mode = 0; m_note = 0; m_oct = 0; m_start = m_edge; m_rptr = 0; m_ovf = 1'b0;
    e_valid = 0; e_note = 0; e_oct = 0; e_dur = 0; e_last = 0;
  endtask

  task automatic model_edge();
    int  dur, kn, co, nd;
    bit  kv, kr;
    m_edge++;
    e_valid = 0;
    e_last  = 0;
    if (clear) begin
      m_buf.delete();
      m_rptr = 0;
      m_ovf  = 1'b0;
      m_mode = 0;
      return;
    end
    if (rd_rewind) begin
      m_rptr = 0;
    end else if (rd_req && m_rptr < m_buf.size()) begin
      e_valid = 1;
      e_note  = m_buf[m_rptr].note;
      e_oct   = m_buf[m_rptr].oct;
      e_dur   = m_buf[m_rptr].dur;
      e_last  = int'(m_rptr + 1 == m_buf.size());
      m_rptr++;
    end
    kv = (popcount7(note_key) == 1);
    kr = (note_key == 0);
    kn = key_idx(note_key);
`ifdef SCORE_REC_OCT_EN
    co = int'(octave);
`else
    co = 0;
`endif
    dur = (m_edge - m_start) / TICK_DIV;
    if (dur > DUR_MAX) dur = DUR_MAX;
    nd = (dur < 1) ? 1 : dur;
    case (m_mode)
      0: if (rec_en && kv) begin
        m_mode = 1; m_note = kn; m_oct = co; m_start = m_edge;
      end
      1: if (!rec_en) begin
        m_commit(m_note, m_oct, nd);
        m_mode = 0;
      end else if (kr) begin
        m_commit(m_note, m_oct, nd);
        m_mode = 2; m_start = m_edge;
      end else if ((kv && kn != m_note) || co != m_oct) begin
        m_commit(m_note, m_oct, nd);
        if (kv) m_note = kn;
        m_oct = co; m_start = m_edge;
      end
      default: if (!rec_en) begin
        m_mode = 0;
      end else if (kv) begin
        if (dur >= 1) m_commit(0, 0, dur);
        m_mode = 1; m_note = kn; m_oct = co; m_start = m_edge;
      end
    endcase
  endtask

  task automatic compare_all();
    check("rd_valid", rd_valid, e_valid);
    check("rd_note", rd_note, e_note);
    check("rd_oct", rd_oct, e_oct);
    check("rd_dur", rd_dur, e_dur);
    check("rd_last", rd_last, e_last);
    check("rd_empty", rd_empty, m_rptr == m_buf.size());
    check("count", count, m_buf.size());
    check("full", full, m_buf.size() == DEPTH);
    check("overflow", overflow, m_ovf);
    check("recording", recording, m_mode != 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    model_reset();
    compare_all();
    rst_n = 1'b1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  task automatic pulse_read();
    rd_req = 1'b1; step(); rd_req = 1'b0;
  endtask

  task automatic play(input logic [6:0] key, input int cycles);
    note_key = key;
    repeat (cycles) step();
  endtask

  task automatic stop_rec();
    rec_en = 1'b0; note_key = '0; step();
  endtask

  task automatic random_phase(input int cycles, input int change_pct);
    for (int c = 0; c < cycles; c++) begin
      int r;
      r = $urandom_range(0, 999);
      if (r < change_pct * 5)       note_key = '0;
      else if (r < change_pct * 10) note_key = 7'(1 << $urandom_range(0, 6));
      else if (r < change_pct * 11) note_key = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 99) < 3)  octave = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) rec_en = ~rec_en;
      clear     = ($urandom_range(0, 299) == 0);
      rd_req    = ($urandom_range(0, 9) == 0);
      rd_rewind = ($urandom_range(0, 59) == 0);
      step();
    end
    clear = 1'b0; rd_req = 1'b0; rd_rewind = 1'b0;
  endtask

  initial begin
    m_edge = 0;
    do_reset();
    check("reset_rd_empty", rd_empty, 1);
    check("reset_count", count, 0);
    step();

    // Note, rest, note with tick-quantised durations.
    rec_en = 1'b1;
    play(7'b0000001, 12);
    play(7'b0000000, 8);
    play(7'b0000100, 20);
    stop_rec();
    check("t1_count", count, 3);
    pulse_read();
    check("t1_e0_valid", rd_valid, 1);
    check("t1_e0_note", rd_note, 1);
    check("t1_e0_dur", rd_dur, 3);
    step();
    check("t1_valid_one_cycle", rd_valid, 0);
    pulse_read();
    check("t1_e1_note", rd_note, 0);
    check("t1_e1_dur", rd_dur, 2);
    check("t1_e1_last", rd_last, 0);
    pulse_read();
    check("t1_e2_note", rd_note, 3);
    check("t1_e2_dur", rd_dur, 5);
    check("t1_e2_last", rd_last, 1);
    pulse_read();
    check("t1_read_empty", rd_valid, 0);
    rd_rewind = 1'b1; step(); rd_rewind = 1'b0;
    pulse_read();
    check("t1_rewind_note", rd_note, 1);
    check("t1_rewind_dur", rd_dur, 3);

    // Short note stored as 1, short rest dropped, direct switch, multi-bit ignored.
    pulse_clear();
    rec_en = 1'b1;
    play(7'b0000001, 2);
    play(7'b0000000, 2);
    play(7'b0000010, 4);
    play(7'b0000100, 4);
    play(7'b0000110, 4);
    stop_rec();
    check("t2_count", count, 3);
    pulse_read();
    check("t2_e0_note", rd_note, 1);
    check("t2_e0_dur", rd_dur, 1);
    pulse_read();
    check("t2_e1_note", rd_note, 2);
    pulse_read();
    check("t2_e2_note", rd_note, 3);
    check("t2_e2_dur", rd_dur, 2);

    // Five notes into four slots.
    pulse_clear();
    rec_en = 1'b1;
    for (int i = 0; i < 5; i++) play(7'(1 << i), 4);
    stop_rec();
    check("t3_count", count, 4);
    check("t3_full", full, 1);
    check("t3_overflow", overflow, 1);
    pulse_clear();
    check("t3_clr_count", count, 0);
    check("t3_clr_overflow", overflow, 0);
    check("t3_clr_empty", rd_empty, 1);

    // Octave change while holding note 5.
    rec_en = 1'b1;
    octave = 2'd1;
    play(7'b0010000, 4);
    octave = 2'd2;
    play(7'b0010000, 4);
    stop_rec();
`ifdef SCORE_REC_OCT_EN
    check("t4_count", count, 2);
    pulse_read();
    check("t4_e0_oct", rd_oct, 1);
    pulse_read();
    check("t4_e1_note", rd_note, 5);
    check("t4_e1_oct", rd_oct, 2);
`else
    check("t4_count", count, 1);
    pulse_read();
    check("t4_e0_note", rd_note, 5);
    check("t4_e0_oct", rd_oct, 0);
    check("t4_e0_dur", rd_dur, 2);
`endif

    // Long hold saturates the duration field.
    pulse_clear();
    octave = 2'd0;
    rec_en = 1'b1;
    play(7'b0000001, 70);
    stop_rec();
    pulse_read();
    check("t5_sat_dur", rd_dur, DUR_MAX);

    rec_en = 1'b1;
    random_phase(3000, 16);
    do_reset();
    random_phase(3000, 2);
    rec_en = 1'b1;
    random_phase(2000, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
